// File: rtl/result_bcd_formatter_if.sv
// result_bcd_formatter_if: input/output handshake bundle for the BCD formatter
// Ports (signals):
//   in_valid/in_ready/in_result/in_error    binary word from the calculator
//   out_valid/out_ready/out_bcd/out_error/out_neg  packed BCD digits to the display
//   busy                                    conversion in progress
// Modports: master drives the inputs and consumes results; slave is the formatter.
interface result_bcd_formatter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_result;
    logic                  in_error;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_error;
    logic                  out_neg;
    logic                  busy;
    modport master (
        output in_valid, in_result, in_error, out_ready,
        input  in_ready, out_valid, out_bcd, out_error, out_neg, busy
    );
    modport slave (
        input  in_valid, in_result, in_error, out_ready,
        output in_ready, out_valid, out_bcd, out_error, out_neg, busy
    );
endinterface

// File: rtl/result_bcd_formatter.sv
// result_bcd_formatter: sequential double-dabble binary-to-BCD converter, one bit per clock
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  result_bcd_formatter_if.slave (input word handshake, BCD output handshake, busy)
// Optional: define BCD_SIGNED_EN to treat in_result as two's complement and report out_neg.
module result_bcd_formatter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    result_bcd_formatter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t              state, state_n;
    logic [WIDTH-1:0]    bin;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] bcd;
    logic [CW-1:0]       cnt;
    logic                err;
    logic                fire;
    genvar g;
    assign fire = (state == IDLE) && bus.in_valid;
    // add-3 correction on every digit before the shift
    for (g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (acc[4*g +: 4] >= 4'd5) ? acc[4*g +: 4] + 4'd3 : acc[4*g +: 4];
    end
`ifdef BCD_SIGNED_EN
    logic neg_p;
    logic neg;
    assign mag = bus.in_result[WIDTH-1] ? ~bus.in_result + 1'b1 : bus.in_result;
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_p <= 1'b0;
            neg   <= 1'b0;
        end else if (fire) begin
            neg_p <= bus.in_result[WIDTH-1];
            if (bus.in_error)
                neg <= 1'b0;
        end else if (state == SHIFT && cnt == LAST) begin
            neg <= neg_p;
        end
    end
    assign bus.out_neg = neg;
`else
    assign mag = bus.in_result;
    assign bus.out_neg = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (fire)
            state_n = bus.in_error ? DONE : SHIFT;
        else if (state == SHIFT && cnt == LAST)
            state_n = DONE;
        else if (state == DONE && bus.out_ready)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bin <= '0;
            acc <= '0;
            cnt <= '0;
            bcd <= '0;
            err <= 1'b0;
        end else if (fire) begin
            acc <= '0;
            if (bus.in_error) begin
                bcd <= {DIGITS{4'hE}};
                err <= 1'b1;
            end else begin
                bin <= mag;
                cnt <= FULL;
            end
        end else if (state == SHIFT) begin
            {acc, bin} <= {adj, bin} << 1;
            cnt <= cnt - LAST;
            // final shift lands directly in the output register
            if (cnt == LAST) begin
                bcd <= {adj[4*DIGITS-2:0], bin[WIDTH-1]};
                err <= 1'b0;
            end
        end
    end
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == SHIFT);
    assign bus.out_bcd   = bcd;
    assign bus.out_error = err;
endmodule

// File: tb/tb_result_bcd_formatter.sv
// tb_result_bcd_formatter: directed self-checking bench for result_bcd_formatter with a decimal reference model
module tb_result_bcd_formatter;
    typedef struct {
        logic [19:0] bcd;
        logic        err;
        logic        neg;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    exp_t exp_q[$];
    logic [19:0] got[$];
    result_bcd_formatter_if #(.WIDTH(16), .DIGITS(5)) bus ();
    result_bcd_formatter #(.WIDTH(16), .DIGITS(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask
    function automatic exp_t model(input logic [15:0] v, input logic e);
        exp_t r;
        int unsigned m;
        r.err = e;
        r.neg = 1'b0;
        r.bcd = 20'hEEEEE;
        if (!e) begin
            m = v;
`ifdef BCD_SIGNED_EN
            if (v[15]) begin
                m = 65536 - m;
                r.neg = 1'b1;
            end
`endif
            for (int i = 0; i < 5; i++) begin
                r.bcd[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
        return r;
    endfunction
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_excl", 32'(bus.in_ready), 32'(!(bus.out_valid || bus.busy)));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("model_bcd", 32'(bus.out_bcd), 32'(exp_q[0].bcd));
                    chk("model_err", 32'(bus.out_error), 32'(exp_q[0].err));
                    chk("model_neg", 32'(bus.out_neg), 32'(exp_q[0].neg));
                    if (bus.out_ready) begin
                        got.push_back(bus.out_bcd);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end
    task automatic send(input logic [15:0] v, input logic e, input logic hold);
        int k = 0;
        bus.in_valid  = 1'b1;
        bus.in_result = v;
        bus.in_error  = e;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100)
            chk("send_timeout", 32'(k), 32'd0);
        exp_q.push_back(model(v, e));
        @(posedge clk); #1;
        if (!hold)
            bus.in_valid = 1'b0;
    endtask
    task automatic latency(output int n);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300)
            chk("idle_timeout", 32'(k), 32'd0);
    endtask
    initial begin
        int n;
        logic [19:0] lit [4];
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_error  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
        chk("rst_out_error", 32'(bus.out_error), 32'd0);
        chk("rst_out_neg", 32'(bus.out_neg), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        send(16'd12345, 1'b0, 1'b0);
        latency(n);
        chk("lat_12345", 32'(n), 32'd17);
        chk("bcd_12345", 32'(bus.out_bcd), 32'h12345);
        chk("err_12345", 32'(bus.out_error), 32'd0);
        wait_idle();
        got.delete();
        send(16'd0, 1'b0, 1'b1);
        send(16'd9, 1'b0, 1'b1);
        send(16'd10, 1'b0, 1'b1);
        send(16'd65535, 1'b0, 1'b0);
        wait_idle();
        lit[0] = 20'h00000;
        lit[1] = 20'h00009;
        lit[2] = 20'h00010;
`ifdef BCD_SIGNED_EN
        lit[3] = 20'h00001;
`else
        lit[3] = 20'h65535;
`endif
        chk("b2b_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("b2b_%0d", i), 32'(got[i]), 32'(lit[i]));
        send(16'h1234, 1'b1, 1'b0);
        latency(n);
        chk("lat_err", 32'(n), 32'd1);
        chk("bcd_err", 32'(bus.out_bcd), 32'hEEEEE);
        chk("flag_err", 32'(bus.out_error), 32'd1);
        wait_idle();
        bus.out_ready = 1'b0;
        send(16'd250, 1'b0, 1'b0);
        latency(n);
        chk("lat_250", 32'(n), 32'd17);
        for (int i = 0; i < 10; i++) begin
            chk("stall_bcd", 32'(bus.out_bcd), 32'h00250);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
        send(16'd4321, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_bcd", 32'(bus.out_bcd), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        send(16'd7, 1'b0, 1'b0);
        latency(n);
        chk("bcd_7", 32'(bus.out_bcd), 32'h00007);
        wait_idle();
        send(16'hFFFE, 1'b0, 1'b0);
        latency(n);
`ifdef BCD_SIGNED_EN
        chk("bcd_fffe", 32'(bus.out_bcd), 32'h00002);
        chk("neg_fffe", 32'(bus.out_neg), 32'd1);
`else
        chk("bcd_fffe", 32'(bus.out_bcd), 32'h65534);
        chk("neg_fffe", 32'(bus.out_neg), 32'd0);
`endif
        wait_idle();
        send(16'h8000, 1'b0, 1'b0);
        latency(n);
        chk("bcd_8000", 32'(bus.out_bcd), 32'h32768);
        wait_idle();
        foreach (lit[i]) lit[i] = 20'h0;
        send(16'd1, 1'b0, 1'b0);
        send(16'd99, 1'b0, 1'b0);
        send(16'd100, 1'b0, 1'b0);
        send(16'd9999, 1'b0, 1'b0);
        send(16'd40000, 1'b0, 1'b0);
        send(16'hABCD, 1'b1, 1'b0);
        send(16'd65534, 1'b0, 1'b0);
        wait_idle();
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
